// File: rtl/glm_scalar_line_packer.sv
// glm_scalar_line_packer
//   Packs 32-bit scalar results from the GLM dot-product unit into 512-bit
//   lines of 16 lanes each. Lines are queued in a small first-word-fall-through
//   FIFO and handed downstream with a lane mask and a last-line marker. The
//   trailing partial line is flushed once the configured scalar count is met.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   op_start          pulse: latch cfg_num_scalars and begin an operation
//   cfg_num_scalars   number of scalars in the operation
//   op_done           one-cycle pulse when the operation is complete
//   in_we, in_wdata   input scalar strobe and data
//   in_almostfull     registered backpressure (FIFO at or above depth-1)
//   out_valid/ready   output line handshake
//   out_data          packed line, lane k = bits [32k+31:32k]
//   out_mask          bit k set when lane k holds a valid scalar
//   out_last          head line is the final line of the operation
//   overflow          sticky: a line was dropped because the FIFO was full
//
// Build option
//   PACKER_ZERO_PAD_EN: unmasked lanes read as zero (line register cleared on
//   every push). Without it unmasked lanes carry stale data.

module glm_scalar_line_packer #(
    parameter int SCALAR_WIDTH          = 32,
    parameter int LOG2_SCALARS_PER_LINE = 4,
    parameter int LOG2_OUT_DEPTH        = 2
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic                                                 op_start,
    input  logic [31:0]                                          cfg_num_scalars,
    output logic                                                 op_done,
    input  logic                                                 in_we,
    input  logic [SCALAR_WIDTH-1:0]                              in_wdata,
    output logic                                                 in_almostfull,
    output logic                                                 out_valid,
    input  logic                                                 out_ready,
    output logic [SCALAR_WIDTH*(2**LOG2_SCALARS_PER_LINE)-1:0]   out_data,
    output logic [(2**LOG2_SCALARS_PER_LINE)-1:0]                out_mask,
    output logic                                                 out_last,
    output logic                                                 overflow
);
    // state | meaning
    // IDLE  | waiting for op_start; in_we ignored
    // PACK  | accepting scalars into the line register
    // DRAIN | last line pushed/dropped; waiting for it to leave the FIFO

    localparam int LANES  = 2**LOG2_SCALARS_PER_LINE;
    localparam int LINE_W = SCALAR_WIDTH*LANES;
    localparam int DEPTH  = 2**LOG2_OUT_DEPTH;
    localparam int CNT_W  = LOG2_OUT_DEPTH+1;

    typedef enum logic [1:0] {IDLE, PACK, DRAIN} state_t;

    state_t                       state;
    logic [31:0]                  n_total;
    logic [31:0]                  cnt;
    logic [31:0]                  cnt_inc;
    logic [LINE_W-1:0]            line_data;
    logic [LINE_W-1:0]            line_next;
    logic [LANES-1:0]             line_mask;
    logic [LANES-1:0]             mask_next;
    logic [LOG2_SCALARS_PER_LINE-1:0] lane;
    logic                         take;
    logic                         is_last;
    logic                         push_req;
    logic                         push_ok;
    logic                         pop;
    logic                         fifo_full;
    logic                         last_dropped;

    logic [LINE_W-1:0]            mem_data [DEPTH];
    logic [LANES-1:0]             mem_mask [DEPTH];
    logic                         mem_last [DEPTH];
    logic [LOG2_OUT_DEPTH-1:0]    wr_ptr;
    logic [LOG2_OUT_DEPTH-1:0]    rd_ptr;
    logic [CNT_W-1:0]             count;
    logic [CNT_W-1:0]             count_next;

    always_comb begin
        lane      = cnt[LOG2_SCALARS_PER_LINE-1:0];
        cnt_inc   = cnt + 32'd1;
        is_last   = (cnt_inc == n_total);
        line_next = line_data;
        line_next[int'(lane)*SCALAR_WIDTH +: SCALAR_WIDTH] = in_wdata;
        mask_next = line_mask | (LANES'(1) << lane);
        take      = (state == PACK) && in_we;
        push_req  = take && ((lane == '1) || is_last);
        fifo_full = (count == CNT_W'(DEPTH));
        pop       = out_valid && out_ready;
        // a pop in the same edge frees the slot, so a full FIFO still accepts
        push_ok   = push_req && (!fifo_full || pop);
        case ({push_ok, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    assign out_valid = (count != '0);
    assign out_data  = mem_data[rd_ptr];
    assign out_mask  = mem_mask[rd_ptr];
    assign out_last  = mem_last[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            n_total      <= '0;
            cnt          <= '0;
            line_mask    <= '0;
            op_done      <= 1'b0;
            overflow     <= 1'b0;
            last_dropped <= 1'b0;
        end else begin
            op_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_start) begin
                        n_total      <= cfg_num_scalars;
                        cnt          <= '0;
                        line_mask    <= '0;
                        overflow     <= 1'b0;
                        last_dropped <= 1'b0;
                        if (cfg_num_scalars == 32'd0) op_done <= 1'b1;
                        else                          state   <= PACK;
                    end
                end
                PACK: begin
                    if (take) begin
                        cnt <= cnt_inc;
                        if (push_req) begin
                            line_mask <= '0;
                            if (!push_ok) overflow <= 1'b1;
                            if (is_last) begin
                                state        <= DRAIN;
                                last_dropped <= !push_ok;
                            end
                        end else begin
                            line_mask <= mask_next;
                        end
                    end
                end
                DRAIN: begin
                    // a dropped last line can never be accepted, so finish once empty
                    if ((pop && out_last) || (last_dropped && count == '0)) begin
                        op_done <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PACKER_ZERO_PAD_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            line_data <= '0;
        end else if ((state == IDLE && op_start) || push_req) begin
            line_data <= '0;
        end else if (take) begin
            line_data <= line_next;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (take) line_data <= line_next;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            in_almostfull <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count         <= count_next;
            in_almostfull <= (count_next >= CNT_W'(DEPTH-1));
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data[wr_ptr] <= line_next;
            mem_mask[wr_ptr] <= mask_next;
            mem_last[wr_ptr] <= is_last;
        end
    end

endmodule
